// File: rtl/tpu_ctrl_pkg.sv
// Shared constants, state encoding and config payload for the TPU tile sequencer.
package tpu_ctrl_pkg;

  localparam int unsigned ADDRESSSIZE      = 10;
  localparam int unsigned ADDRESSSIZE_FIFO = 2;
  localparam int unsigned PIPE_LAT         = 18;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_W_RD   = 3'd1,
    S_RELOAD = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDRESSSIZE-1:0]      rows;
    logic [ADDRESSSIZE-1:0]      res_base;
    logic [ADDRESSSIZE-1:0]      ub_base;
    logic [ADDRESSSIZE_FIFO-1:0] w_sel;
  } tile_cfg_t;

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Host config handshake plus UB / weight SRAM / array / results SRAM control bundle.
interface tpu_tile_sequencer_if;
  import tpu_ctrl_pkg::*;

  logic                        start;
  logic [ADDRESSSIZE_FIFO-1:0] cfg_w_sel;
  logic [ADDRESSSIZE-1:0]      cfg_ub_base;
  logic [ADDRESSSIZE-1:0]      cfg_res_base;
  logic [ADDRESSSIZE-1:0]      cfg_rows;
  logic                        busy;
  logic                        done;
  logic [ADDRESSSIZE_FIFO-1:0] w_addr;
  logic                        we_rl;
  logic                        ub_re;
  logic [ADDRESSSIZE-1:0]      ub_addr;
  logic                        res_we;
  logic [ADDRESSSIZE-1:0]      res_addr;

  modport master (
    output start, cfg_w_sel, cfg_ub_base, cfg_res_base, cfg_rows,
    input  busy, done, w_addr, we_rl, ub_re, ub_addr, res_we, res_addr
  );

  modport slave (
    input  start, cfg_w_sel, cfg_ub_base, cfg_res_base, cfg_rows,
    output busy, done, w_addr, we_rl, ub_re, ub_addr, res_we, res_addr
  );

endinterface

// File: rtl/ctrl_valid_delay.sv
// Fixed-depth valid delay line; tap aligns row reads with result writes, any-flag marks rows in flight.
module ctrl_valid_delay #(
  parameter int unsigned DEPTH = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_tap,
  output logic o_any
);

  logic [DEPTH-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[DEPTH-2:0], i_din};
    end
  end

  assign o_tap = r_sh[DEPTH-1];
  assign o_any = |r_sh;

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Runs one tile: weight-set select and reload, UB row stream, and aligned result writes,
// under a start/busy/done handshake.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  tpu_tile_sequencer_if.slave  io_seq
);

  state_t                 r_state;
  tile_cfg_t              r_cfg;
  logic [ADDRESSSIZE-1:0] r_cnt;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_we_rl;
  logic                   r_ub_re;
  logic                   w_res_we;
  logic                   w_inflight;

  ctrl_valid_delay #(.DEPTH(PIPE_LAT)) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .i_din (r_ub_re),
    .o_tap (w_res_we),
    .o_any (w_inflight)
  );

  // A new start may also be taken in DONE so back-to-back tiles lose no cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cfg      <= '0;
      r_cnt      <= '0;
      r_ub_addr  <= '0;
      r_res_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_we_rl    <= 1'b0;
      r_ub_re    <= 1'b0;
    end else begin
      r_we_rl <= 1'b0;
      r_done  <= 1'b0;
      if (w_res_we) begin
        r_res_addr <= r_res_addr + ADDRESSSIZE'(1);
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (io_seq.start) begin
            r_cfg.w_sel    <= io_seq.cfg_w_sel;
            r_cfg.ub_base  <= io_seq.cfg_ub_base;
            r_cfg.res_base <= io_seq.cfg_res_base;
            r_cfg.rows     <= io_seq.cfg_rows;
            r_busy         <= 1'b1;
            r_state        <= S_W_RD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_W_RD: begin
          r_we_rl <= 1'b1;
          r_state <= S_RELOAD;
        end
        S_RELOAD: begin
          r_res_addr <= r_cfg.res_base;
          if (r_cfg.rows == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_ub_re   <= 1'b1;
            r_ub_addr <= r_cfg.ub_base;
            r_cnt     <= ADDRESSSIZE'(1);
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_cnt == r_cfg.rows) begin
            r_ub_re <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_ub_addr <= r_ub_addr + ADDRESSSIZE'(1);
            r_cnt     <= r_cnt + ADDRESSSIZE'(1);
          end
        end
        S_DRAIN: begin
          if (!w_inflight) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_seq.busy     = r_busy;
  assign io_seq.done     = r_done;
  assign io_seq.w_addr   = r_cfg.w_sel;
  assign io_seq.we_rl    = r_we_rl;
  assign io_seq.ub_re    = r_ub_re;
  assign io_seq.ub_addr  = r_ub_addr;
  assign io_seq.res_we   = w_res_we;
  assign io_seq.res_addr = r_res_addr;

endmodule
